// File: rtl/or_share_arbiter_pkg.sv
// Shared FSM encodings and elaboration helpers for the OR-share arbiter.
package or_share_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EVAL = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Returns at least 1 so that index ports are never zero width.
  function automatic int clog2_f(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/or_gate.sv
// Single-bit OR cell; one instance per datapath bit.
module or_gate (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a | b;
endmodule

// File: rtl/or_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_priority_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = 0; k < N; k++) begin
      // Explicit wrap keeps non-power-of-two N correct.
      int j;
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!any && req[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = IW'(j);
      end
    end
  end
endmodule

// File: rtl/or_share_arbiter.sv
// Round-robin sharing of one registered OR datapath among NUM_REQ requesters.
module or_share_arbiter
  import or_share_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 1,
  parameter int ID_W    = clog2_f(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_out,
  output logic                      busy
);

  state_t              state, state_n;
  logic [ID_W-1:0]     rr_ptr;
  logic [DATA_W-1:0]   op_a, op_b, or_y;
  logic [NUM_REQ-1:0]  grant;
  logic [ID_W-1:0]     win;
  logic                any;

  rr_priority_pick #(.N(NUM_REQ), .IW(ID_W)) u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (win),
    .any   (any)
  );

  for (genvar g = 0; g < DATA_W; g++) begin : g_or
    or_gate u_or (.a(op_a[g]), .b(op_b[g]), .y(or_y[g]));
  end

  // Ready is gated by rst_n so it reads 0 while reset is held.
  assign req_ready = (state == S_IDLE && rst_n) ? grant : '0;
  assign busy      = (state != S_IDLE);

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (any) state_n = S_EVAL;
      S_EVAL:  state_n = S_RESP;
      S_RESP:  if (rsp_ready) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      rr_ptr    <= '0;
      op_a      <= '0;
      op_b      <= '0;
      rsp_id    <= '0;
      rsp_out   <= '0;
      rsp_valid <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        S_IDLE: if (any) begin
          op_a   <= req_a[win*DATA_W +: DATA_W];
          op_b   <= req_b[win*DATA_W +: DATA_W];
          rsp_id <= win;
        end
        S_EVAL: begin
          rsp_out   <= or_y;
          rsp_valid <= 1'b1;
        end
        S_RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          rr_ptr    <= (rsp_id == ID_W'(NUM_REQ-1)) ? '0 : rsp_id + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_or_share_arbiter.sv
// Directed bench for or_share_arbiter with NUM_REQ=4, DATA_W=1.
module tb_or_share_arbiter;
  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 1;
  localparam int ID_W    = 2;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic [NUM_REQ-1:0]        req_valid, req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_a, req_b;
  logic                      rsp_valid, rsp_ready, busy;
  logic [ID_W-1:0]           rsp_id;
  logic [DATA_W-1:0]         rsp_out;

  int checks = 0;
  int errors = 0;

  or_share_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_out(rsp_out), .busy(busy)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; checks happen on the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_valid = 4'($urandom);
      req_a     = 4'($urandom);
      req_b     = 4'($urandom);
      rsp_ready = 1'($urandom);
      @(negedge clk);
      checks++;
      if ({req_ready, rsp_valid, rsp_id, rsp_out, busy} !== '0) begin
        errors++;
        $display("FAIL reset_outputs: got ready=%b v=%b id=%0d out=%b busy=%b, want all 0",
                 req_ready, rsp_valid, rsp_id, rsp_out, busy);
      end
      step();
    end
    req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || req_ready !== 4'b0000) begin
        errors++;
        $display("FAIL reset_idle: got busy=%b ready=%b, want 0/0000", busy, req_ready);
      end
      step();
    end
  endtask

  task automatic test_single();
    req_valid = 4'b0001; req_a = 4'b0000; req_b = 4'b0001;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++; $display("FAIL single_ready: got %b want 0001", req_ready);
    end
    step();
    req_valid = '0;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b1 || req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL single_eval: got v=%b busy=%b ready=%b want 0/1/0000", rsp_valid, busy, req_ready);
    end
    step();
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_out !== 1'b1) begin
      errors++;
      $display("FAIL single_rsp: got v=%b id=%0d out=%b want 1/0/1", rsp_valid, rsp_id, rsp_out);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic test_truth_table();
    logic [1:0] ab [4];
    logic       exp [4];
    ab  = '{2'b00, 2'b01, 2'b10, 2'b11};
    exp = '{1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      req_valid = 4'b0100;
      req_a = '0; req_b = '0;
      req_a[2] = ab[i][1];
      req_b[2] = ab[i][0];
      @(negedge clk);
      checks++;
      if (req_ready !== 4'b0100) begin
        errors++; $display("FAIL tt_ready[%0d]: got %b want 0100", i, req_ready);
      end
      step();
      req_valid = '0;
      step();
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_out !== exp[i]) begin
        errors++;
        $display("FAIL tt_rsp[%0d]: got v=%b id=%0d out=%b want 1/2/%b", i, rsp_valid, rsp_id, rsp_out, exp[i]);
      end
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
    end
  endtask

  task automatic test_fairness();
    int order [6];
    order = '{0, 1, 2, 3, 0, 1};
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    step();
    req_valid = 4'b1111; req_a = 4'b0101; req_b = 4'b0000; rsp_ready = 1'b1;
    for (int g = 0; g < 6; g++) begin
      @(negedge clk);
      checks++;
      if (req_ready !== (4'b0001 << order[g]) || $countones(req_ready) > 1) begin
        errors++;
        $display("FAIL fair_grant[%0d]: got %b want %b", g, req_ready, 4'b0001 << order[g]);
      end
      step();
      @(negedge clk);
      checks++;
      if (req_ready !== 4'b0000 || rsp_valid !== 1'b0) begin
        errors++; $display("FAIL fair_eval[%0d]: got ready=%b v=%b want 0000/0", g, req_ready, rsp_valid);
      end
      step();
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'(order[g]) || rsp_out !== 1'((order[g] + 1) % 2)) begin
        errors++;
        $display("FAIL fair_rsp[%0d]: got v=%b id=%0d out=%b want 1/%0d/%0d",
                 g, rsp_valid, rsp_id, rsp_out, order[g], (order[g] + 1) % 2);
      end
      step();
    end
    rsp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    // rr_ptr is 2 after the fairness run; requester 2 has a=1.
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++; $display("FAIL bp_grant: got %b want 0100", req_ready);
    end
    step();
    step();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_out !== 1'b1 || req_ready !== 4'b0000) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got v=%b id=%0d out=%b ready=%b want 1/2/1/0000",
                 c, rsp_valid, rsp_id, rsp_out, req_ready);
      end
      step();
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 4'b1000) begin
      errors++; $display("FAIL bp_next: got v=%b ready=%b want 0/1000", rsp_valid, req_ready);
    end
  endtask

  task automatic test_reset_mid();
    step();
    step();
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd3) begin
      errors++; $display("FAIL mid_pre: got v=%b id=%0d want 1/3", rsp_valid, rsp_id);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || rsp_id !== 2'd0 || req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL mid_async: got v=%b busy=%b id=%0d ready=%b want 0/0/0/0000",
               rsp_valid, busy, rsp_id, req_ready);
    end
    step();
    req_valid = 4'b1010;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++; $display("FAIL mid_regrant: got %b want 0010", req_ready);
    end
    step();
    req_valid = '0;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    #1;
    test_reset();
    test_single();
    test_truth_table();
    test_fairness();
    test_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
